pipe_mult_ctrl: RTL and testbench

- Parametrised N-stage pipelined integer multiplier with a valid/ready handshake, global backpressure, flush and a tag sideband.
- Supports four RISC-V-style result modes: low, signed-high, signed×unsigned-high and unsigned-high.
- Sits in the execute stage as the long-latency functional unit.
- Each stage consumes XLEN/NSTAGE multiplier bits, keeping the per-stage adder short.

---
 rtl/pipe_mult_ctrl.sv | 106 ++++++++++
 tb/tb_pipe_mult_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_mult_ctrl.sv
// pipe_mult_ctrl: NSTAGE-deep pipelined multiplier with valid/ready, flush and tag sideband.
// Each stage folds NBIT multiplier bits into a 2*XLEN accumulator on sign-magnitude operands.
module pipe_mult_ctrl #(
    parameter int XLEN   = 64,
    parameter int NSTAGE = 8,
    parameter int TAGW   = 6
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_mode,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    input  logic [TAGW-1:0] in_tag,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [TAGW-1:0] out_tag,
    output logic            busy
);
    localparam int NBIT = XLEN / NSTAGE;
    localparam int L    = NSTAGE - 1;

    logic [NSTAGE-1:0] vld, neg;
    logic [2*XLEN-1:0] acc    [NSTAGE];
    logic [2*XLEN-1:0] mcand  [NSTAGE];
    logic [XLEN-1:0]   mplier [NSTAGE];
    logic [1:0]        mode   [NSTAGE];
    logic [TAGW-1:0]   tag    [NSTAGE];

    logic [NSTAGE-1:0] s_vld, s_neg;
    logic [2*XLEN-1:0] s_acc [NSTAGE], s_mcand [NSTAGE], n_acc [NSTAGE], n_mcand [NSTAGE];
    logic [XLEN-1:0]   s_mplier [NSTAGE], n_mplier [NSTAGE];
    logic [1:0]        s_mode [NSTAGE];
    logic [TAGW-1:0]   s_tag  [NSTAGE];

    logic            adv, sign_a, sign_b;
    logic [XLEN-1:0] abs_a, abs_b;
    logic [2*XLEN-1:0] prod;

    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv && !flush;
    assign out_valid = vld[L];
    assign busy      = |vld;
    assign out_tag   = tag[L];

    assign sign_a = in_a[XLEN-1] && (in_mode[0] ^ in_mode[1]);
    assign sign_b = in_b[XLEN-1] && (in_mode == 2'b01);
    assign abs_a  = sign_a ? -in_a : in_a;
    assign abs_b  = sign_b ? -in_b : in_b;

    assign prod       = neg[L] ? -acc[L] : acc[L];
    assign out_result = (mode[L] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

    for (genvar i = 0; i < NSTAGE; i++) begin : g_stage
        if (i == 0) begin : g_first
            assign s_vld[i]    = in_valid;
            assign s_neg[i]    = sign_a ^ sign_b;
            assign s_acc[i]    = '0;
            assign s_mcand[i]  = {{XLEN{1'b0}}, abs_a};
            assign s_mplier[i] = abs_b;
            assign s_mode[i]   = in_mode;
            assign s_tag[i]    = in_tag;
        end else begin : g_next
            assign s_vld[i]    = vld[i-1];
            assign s_neg[i]    = neg[i-1];
            assign s_acc[i]    = acc[i-1];
            assign s_mcand[i]  = mcand[i-1];
            assign s_mplier[i] = mplier[i-1];
            assign s_mode[i]   = mode[i-1];
            assign s_tag[i]    = tag[i-1];
        end
        assign n_acc[i]    = s_acc[i] + ({{(2*XLEN-NBIT){1'b0}}, s_mplier[i][NBIT-1:0]} * s_mcand[i]);
        assign n_mcand[i]  = s_mcand[i] << NBIT;
        assign n_mplier[i] = s_mplier[i] >> NBIT;
    end

    // Data registers shift even behind invalid slots; only the valid bits must be exact.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld <= '0;
            neg <= '0;
            for (int s = 0; s < NSTAGE; s++) begin
                acc[s]    <= '0;
                mcand[s]  <= '0;
                mplier[s] <= '0;
                mode[s]   <= '0;
                tag[s]    <= '0;
            end
        end else if (flush) begin
            vld <= '0;
        end else if (adv) begin
            vld <= s_vld;
            neg <= s_neg;
            for (int s = 0; s < NSTAGE; s++) begin
                acc[s]    <= n_acc[s];
                mcand[s]  <= n_mcand[s];
                mplier[s] <= n_mplier[s];
                mode[s]   <= s_mode[s];
                tag[s]    <= s_tag[s];
            end
        end
    end
endmodule

// File: tb/tb_pipe_mult_ctrl.sv
// tb_pipe_mult_ctrl: directed stimulus with a queue-based product model checked every cycle.
module tb_pipe_mult_ctrl;
    localparam int XLEN = 64, NSTAGE = 8, TAGW = 6;

    logic clock = 0, reset = 1, flush = 0, in_valid = 0, out_ready = 1;
    logic [1:0] in_mode = 0;
    logic [XLEN-1:0] in_a = 0, in_b = 0;
    logic [TAGW-1:0] in_tag = 0;
    logic in_ready, out_valid, busy;
    logic [XLEN-1:0] out_result;
    logic [TAGW-1:0] out_tag;

    int checks = 0, errors = 0;

    pipe_mult_ctrl #(.XLEN(XLEN), .NSTAGE(NSTAGE), .TAGW(TAGW)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    // Full 128-bit product of sign/zero-extended operands, then pick the requested half.
    function automatic logic [63:0] model(input logic [1:0] m, input logic [63:0] a, input logic [63:0] b);
        logic [127:0] ea, eb, p;
        ea = (m == 2'd1 || m == 2'd2) ? {{64{a[63]}}, a} : {64'd0, a};
        eb = (m == 2'd1) ? {{64{b[63]}}, b} : {64'd0, b};
        p  = ea * eb;
        return (m == 2'd0) ? p[63:0] : p[127:64];
    endfunction

    logic [63:0]     qr [$];
    logic [TAGW-1:0] qt [$];
    int              qs [$];
    int              adv_cnt = 0;

    function automatic logic exp_valid();
        return qr.size() != 0 && (adv_cnt - qs[0]) >= NSTAGE - 1;
    endfunction

    // Oldest op becomes visible once it has ridden NSTAGE-1 advancing edges.
    initial forever begin
        logic ev;
        @(posedge clock or posedge reset);
        if (reset || flush) begin
            qr.delete(); qt.delete(); qs.delete();
        end else begin
            ev = exp_valid();
            if (!ev || out_ready) begin
                if (ev) begin
                    void'(qr.pop_front()); void'(qt.pop_front()); void'(qs.pop_front());
                end
                adv_cnt++;
                if (in_valid) begin
                    qr.push_back(model(in_mode, in_a, in_b));
                    qt.push_back(in_tag);
                    qs.push_back(adv_cnt);
                end
            end
        end
    end

    initial forever begin
        logic ev;
        @(negedge clock);
        if (!reset) begin
            ev = exp_valid();
            chk("cmp_out_valid", 64'(out_valid), 64'(ev));
            chk("cmp_in_ready", 64'(in_ready), 64'((!ev || out_ready) && !flush));
            chk("cmp_busy", 64'(busy), 64'(qr.size() != 0));
            if (ev) begin
                chk("cmp_result", out_result, qr[0]);
                chk("cmp_tag", 64'(out_tag), 64'(qt[0]));
            end
        end
    end

    task automatic run_one(input string n, input logic [1:0] m, input logic [63:0] a,
                           input logic [63:0] b, input logic [TAGW-1:0] t, input logic [63:0] exp);
        int lat;
        @(posedge clock); #1;
        in_valid = 1; in_mode = m; in_a = a; in_b = b; in_tag = t; out_ready = 1;
        @(posedge clock); #1;
        in_valid = 0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clock); #1;
            lat++;
        end
        chk({n, "_latency"}, 64'(lat), 64'(NSTAGE));
        chk({n, "_result"}, out_result, exp);
        chk({n, "_tag"}, 64'(out_tag), 64'(t));
        @(posedge clock); #1;
        chk({n, "_busy_after"}, 64'(busy), 64'd0);
        chk({n, "_valid_after"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        int idx, ret, stall_left, guard, w;
        logic stalled, acc_now, ret_now;
        logic [63:0] frozen;

        #23 reset = 0;
        @(negedge clock);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_result", out_result, 64'd0);
        chk("rst_tag", 64'(out_tag), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        chk("model_mulh_m1", model(2'd1, '1, '1), 64'd0);
        chk("model_mulhu_m1", model(2'd3, '1, '1), 64'hFFFF_FFFF_FFFF_FFFE);
        chk("model_mulhsu", model(2'd2, '1, 64'd2), 64'hFFFF_FFFF_FFFF_FFFF);

        run_one("mul_3x5", 2'd0, 64'd3, 64'd5, 6'h2A, 64'd15);
        run_one("mulh_m1", 2'd1, '1, '1, 6'h01, 64'd0);
        run_one("mulhu_m1", 2'd3, '1, '1, 6'h02, 64'hFFFF_FFFF_FFFF_FFFE);
        run_one("mulhsu_m1x2", 2'd2, '1, 64'd2, 6'h03, 64'hFFFF_FFFF_FFFF_FFFF);
        run_one("mulh_min", 2'd1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 6'h04, 64'h4000_0000_0000_0000);
        run_one("mul_min", 2'd0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 6'h05, 64'd0);

        // Back-to-back stream with a 3-cycle consumer stall once the pipe is full.
        idx = 0; ret = 0; stall_left = 0; guard = 0; stalled = 0; frozen = 0;
        @(posedge clock); #1;
        in_valid = 1; in_mode = 0; in_a = 0; in_b = 1; in_tag = 0; out_ready = 1;
        while (ret < 10 && guard < 200) begin
            @(negedge clock);
            acc_now = in_valid && in_ready;
            ret_now = out_valid && out_ready;
            if (!out_ready) begin
                chk("stall_in_ready", 64'(in_ready), 64'd0);
                chk("stall_frozen", out_result, frozen);
            end
            if (ret_now) begin
                chk("stream_product", out_result, 64'(ret * (ret + 1)));
                chk("stream_order", 64'(out_tag), 64'(ret));
            end
            @(posedge clock); #1;
            guard++;
            if (acc_now) idx++;
            if (ret_now) ret++;
            if (stall_left > 0) begin
                stall_left--;
                if (stall_left == 0) out_ready = 1;
            end else if (!stalled && out_valid && idx == NSTAGE) begin
                out_ready = 0; frozen = out_result; stall_left = 3; stalled = 1;
            end
            in_valid = idx < 10;
            in_a = 64'(idx); in_b = 64'(idx + 1); in_tag = TAGW'(idx);
        end
        in_valid = 0; out_ready = 1;
        chk("stream_retired", 64'(ret), 64'd10);
        chk("stream_stalled", 64'(stalled), 64'd1);

        // Flush with four in flight and a fifth offered on the flush cycle.
        @(posedge clock); #1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1; in_mode = 0; in_a = 64'(i + 7); in_b = 64'd3; in_tag = TAGW'(i + 20);
            @(posedge clock); #1;
        end
        flush = 1; in_a = 64'd99; in_tag = 6'h30;
        @(negedge clock);
        chk("flush_in_ready", 64'(in_ready), 64'd0);
        @(posedge clock); #1;
        flush = 0; in_valid = 0;
        chk("flush_busy", 64'(busy), 64'd0);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        repeat (12) begin
            @(negedge clock);
            chk("flush_no_out", 64'(out_valid), 64'd0);
        end
        run_one("post_flush", 2'd0, 64'd6, 64'd7, 6'h09, 64'd42);

        // Asynchronous reset with three results parked behind a stalled consumer.
        @(posedge clock); #1;
        out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1; in_mode = 0; in_a = 64'(i + 2); in_b = 64'd5; in_tag = TAGW'(i + 40);
            @(posedge clock); #1;
        end
        in_valid = 0;
        w = 0;
        while (!out_valid && w < 20) begin
            @(posedge clock); #1;
            w++;
        end
        chk("prerst_valid", 64'(out_valid), 64'd1);
        chk("prerst_result", out_result, 64'd10);
        #2 reset = 1;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_result", out_result, 64'd0);
        chk("arst_tag", 64'(out_tag), 64'd0);
        @(negedge clock); #2;
        reset = 0; out_ready = 1;
        repeat (20) begin
            @(negedge clock);
            chk("arst_no_stale", 64'(out_valid), 64'd0);
        end
        chk("model_drained", 64'(qr.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
